// File: rtl/fc_tx_credit.sv
// Buffer-to-buffer credit gate in front of the FC transmit framer.
// Forwards host frames only while credit is available and injects R_RDY words between frames.
module fc_tx_credit #(
  parameter int unsigned BB_CREDIT = 8,
  parameter int unsigned CREDIT_W  = 4,
  parameter int unsigned PEND_W    = 4,
  parameter logic [31:0] RRDY_WORD = 32'hBC95_4A4A
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic [31:0]         i_in_data,
  input  logic                i_in_valid,
  output logic                o_in_ready,
  input  logic                i_in_startofpacket,
  input  logic                i_in_endofpacket,
  output logic [31:0]         o_out_data,
  output logic                o_out_valid,
  input  logic                i_out_ready,
  output logic                o_out_startofpacket,
  output logic                o_out_endofpacket,
  input  logic                i_link_active,
  input  logic                i_rx_rrdy,
  input  logic                i_rx_frame_done,
  output logic [CREDIT_W-1:0] o_credit_avail,
  output logic [PEND_W-1:0]   o_rrdy_pending,
  output logic                o_credit_error,
  output logic [15:0]         o_drop_count
);

  typedef enum logic [1:0] {StIdle, StFrame, StRrdy} state_e;

  localparam logic [CREDIT_W-1:0] CreditMax = CREDIT_W'(BB_CREDIT);
  localparam logic [PEND_W-1:0]   PendMax   = '1;

  state_e              r_state;
  state_e              w_state_d;
  logic                r_link_q;
  logic [CREDIT_W-1:0] r_credit;
  logic [CREDIT_W-1:0] w_credit_d;
  logic [PEND_W-1:0]   r_pend;
  logic [PEND_W-1:0]   w_pend_d;
  logic                r_err;
  logic                w_err_d;
  logic [15:0]         r_drop;
  logic [15:0]         w_drop_d;
  logic                w_out_valid;
  logic                w_in_ready;
  logic                w_sof_hs;
  logic                w_rrdy_hs;
  logic                w_drop;

  always_comb begin
    w_state_d           = r_state;
    w_out_valid         = 1'b0;
    w_in_ready          = 1'b0;
    o_out_data          = i_in_data;
    o_out_startofpacket = i_in_startofpacket;
    o_out_endofpacket   = i_in_endofpacket;
    w_sof_hs            = 1'b0;
    w_rrdy_hs           = 1'b0;
    w_drop              = 1'b0;
    case (r_state)
      StIdle: begin
        if (r_pend != '0 && i_link_active) begin
          w_state_d = StRrdy;
        end else if (i_in_valid && i_in_startofpacket && i_link_active && r_credit != '0) begin
          w_out_valid = 1'b1;
          w_in_ready  = i_out_ready;
          if (i_out_ready) begin
            w_sof_hs = 1'b1;
            if (!i_in_endofpacket) w_state_d = StFrame;
          end
        end else if (i_in_valid && !i_in_startofpacket) begin
          w_in_ready = 1'b1;
          w_drop     = 1'b1;
        end
      end
      StFrame: begin
        // Frames already started run to EOF regardless of link state.
        w_out_valid = i_in_valid;
        w_in_ready  = i_out_ready;
        if (i_in_valid && i_out_ready && i_in_endofpacket) w_state_d = StIdle;
      end
      StRrdy: begin
        o_out_data          = RRDY_WORD;
        o_out_startofpacket = 1'b1;
        o_out_endofpacket   = 1'b1;
        if (!i_link_active) begin
          w_state_d = StIdle;
        end else begin
          w_out_valid = 1'b1;
          if (i_out_ready) begin
            w_rrdy_hs = 1'b1;
            w_state_d = StIdle;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Handshake outputs are forced low for the whole time reset is held.
  assign o_out_valid = w_out_valid & i_reset_n;
  assign o_in_ready  = w_in_ready & i_reset_n;

  always_comb begin
    w_credit_d = r_credit;
    w_err_d    = r_err;
    if (!i_link_active) begin
      w_credit_d = '0;
    end else if (!r_link_q) begin
      w_credit_d = CreditMax;
      w_err_d    = 1'b0;
    end else if (w_sof_hs && !i_rx_rrdy) begin
      w_credit_d = r_credit - CREDIT_W'(1);
    end else if (i_rx_rrdy && !w_sof_hs) begin
      if (r_credit == CreditMax) w_err_d = 1'b1;
      else w_credit_d = r_credit + CREDIT_W'(1);
    end
  end

  always_comb begin
    w_pend_d = r_pend;
    if (!i_link_active) begin
      w_pend_d = '0;
    end else if (i_rx_frame_done && !w_rrdy_hs) begin
      if (r_pend != PendMax) w_pend_d = r_pend + PEND_W'(1);
    end else if (w_rrdy_hs && !i_rx_frame_done) begin
      w_pend_d = r_pend - PEND_W'(1);
    end
  end

  always_comb begin
    w_drop_d = r_drop;
    if (w_drop && r_drop != 16'hFFFF) w_drop_d = r_drop + 16'd1;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state  <= StIdle;
      r_link_q <= 1'b0;
      r_credit <= '0;
      r_pend   <= '0;
      r_err    <= 1'b0;
      r_drop   <= '0;
    end else begin
      r_state  <= w_state_d;
      r_link_q <= i_link_active;
      r_credit <= w_credit_d;
      r_pend   <= w_pend_d;
      r_err    <= w_err_d;
      r_drop   <= w_drop_d;
    end
  end

  assign o_credit_avail = r_credit;
  assign o_rrdy_pending = r_pend;
  assign o_credit_error = r_err;
  assign o_drop_count   = r_drop;

endmodule

// File: tb/tb_fc_tx_credit.sv
// Self-checking bench for fc_tx_credit: fixed vector table, directed corner sequences,
// then random traffic checked against a cycle-level behavioural model.
module tb_fc_tx_credit;

  localparam int          BB    = 8;
  localparam logic [31:0] RRDY  = 32'hBC95_4A4A;
  localparam logic [31:0] SOFI3 = 32'hBCB5_5656;
  localparam logic [31:0] EOFT  = 32'hBC95_7575;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
  logic        out_ready = 1'b1, link = 1'b0, rx_rrdy = 1'b0, rx_done = 1'b0;
  logic        in_ready, out_valid, out_sop, out_eop, credit_error;
  logic [31:0] out_data;
  logic [3:0]  credit_avail, rrdy_pending;
  logic [15:0] drop_count;

  fc_tx_credit #(
    .BB_CREDIT(BB), .CREDIT_W(4), .PEND_W(4), .RRDY_WORD(RRDY)
  ) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_in_data(in_data), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_startofpacket(in_sop), .i_in_endofpacket(in_eop),
    .o_out_data(out_data), .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_startofpacket(out_sop), .o_out_endofpacket(out_eop),
    .i_link_active(link), .i_rx_rrdy(rx_rrdy), .i_rx_frame_done(rx_done),
    .o_credit_avail(credit_avail), .o_rrdy_pending(rrdy_pending),
    .o_credit_error(credit_error), .o_drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: mode 0 = between frames, 1 = inside a frame, 2 = sending R_RDY.
  int m_mode, m_credit, m_pend, m_drop;
  bit m_err, m_link_prev;
  bit e_ov, e_ir, e_sop, e_eop, e_sof, e_rr, e_drop, last_hs;
  logic [31:0] e_od;
  int e_next;
  bit rdy_toggle = 1'b0;

  typedef struct {
    bit lk, v, s, e; logic [31:0] d; bit rdy, rr, rd;
    bit eov, eir; int ecred, epend;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_credit = 0; m_pend = 0; m_drop = 0; m_err = 0; m_link_prev = 0;
  endtask

  task automatic model_eval();
    e_ov = 0; e_ir = 0; e_od = in_data; e_sop = in_sop; e_eop = in_eop;
    e_sof = 0; e_rr = 0; e_drop = 0; e_next = m_mode;
    case (m_mode)
      0: begin
        if (m_pend > 0 && link) e_next = 2;
        else if (in_valid && in_sop && link && m_credit > 0) begin
          e_ov = 1; e_ir = out_ready;
          if (out_ready) begin e_sof = 1; e_next = in_eop ? 0 : 1; end
        end else if (in_valid && !in_sop) begin
          e_ir = 1; e_drop = 1;
        end
      end
      1: begin
        e_ov = in_valid; e_ir = out_ready;
        if (in_valid && out_ready && in_eop) e_next = 0;
      end
      default: begin
        e_od = RRDY; e_sop = 1; e_eop = 1; e_next = 0;
        if (link) begin
          e_ov = 1; e_rr = out_ready;
          if (!out_ready) e_next = 2;
        end
      end
    endcase
  endtask

  task automatic model_update();
    if (!link) begin
      m_credit = 0; m_pend = 0;
    end else begin
      if (!m_link_prev) begin
        m_credit = BB; m_err = 0;
      end else if (e_sof && !rx_rrdy) m_credit--;
      else if (rx_rrdy && !e_sof) begin
        if (m_credit == BB) m_err = 1; else m_credit++;
      end
      if (rx_done && !e_rr) begin
        if (m_pend < 15) m_pend++;
      end else if (e_rr && !rx_done) m_pend--;
    end
    if (e_drop && m_drop < 65535) m_drop++;
    m_link_prev = link;
    m_mode = e_next;
  endtask

  // Inputs are driven 1 time unit after posedge; outputs are sampled at the following negedge.
  task automatic step_eval();
    #4;
    model_eval();
    last_hs = e_ir && in_valid;
    chk("out_valid", {31'd0, out_valid}, {31'd0, e_ov});
    chk("in_ready", {31'd0, in_ready}, {31'd0, e_ir});
    if (e_ov) begin
      chk("out_data", out_data, e_od);
      chk("out_sop", {31'd0, out_sop}, {31'd0, e_sop});
      chk("out_eop", {31'd0, out_eop}, {31'd0, e_eop});
    end
    chk("credit_avail", {28'd0, credit_avail}, m_credit);
    chk("rrdy_pending", {28'd0, rrdy_pending}, m_pend);
    chk("credit_error", {31'd0, credit_error}, {31'd0, m_err});
    chk("drop_count", {16'd0, drop_count}, m_drop);
  endtask

  task automatic step_adv();
    @(posedge clk);
    model_update();
    #1;
    rx_rrdy = 0; rx_done = 0;
  endtask

  task automatic step();
    step_eval();
    step_adv();
  endtask

  task automatic xfer(input logic [31:0] d, input bit s, input bit e);
    bit done = 0;
    in_valid = 1; in_data = d; in_sop = s; in_eop = e;
    for (int n = 0; n < 40 && !done; n++) begin
      if (rdy_toggle) out_ready = ~out_ready;
      step();
      done = last_hs;
    end
    if (!done) chk("xfer_timeout", 32'd0, 32'd1);
    in_valid = 0; in_sop = 0; in_eop = 0;
  endtask

  task automatic reset_check(input string tag);
    rst_n = 0;
    #1;
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_credit"}, {28'd0, credit_avail}, 32'd0);
    chk({tag, "_pending"}, {28'd0, rrdy_pending}, 32'd0);
    chk({tag, "_error"}, {31'd0, credit_error}, 32'd0);
    chk({tag, "_drop"}, {16'd0, drop_count}, 32'd0);
    model_reset();
    in_valid = 0; in_sop = 0; in_eop = 0; out_ready = 1;
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic add(input bit lk, v, s, e, input logic [31:0] d, input bit rdy, rr, rd,
                     input bit eov, eir, input int ecred, epend);
    vec_t t;
    t.lk = lk; t.v = v; t.s = s; t.e = e; t.d = d; t.rdy = rdy; t.rr = rr; t.rd = rd;
    t.eov = eov; t.eir = eir; t.ecred = ecred; t.epend = epend;
    tbl.push_back(t);
  endtask

  int rrdy_seen;

  initial begin
    // Vector table: link-up, one full frame, three stray words, one R_RDY round trip.
    add(1, 0, 0, 0, 32'h0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 32'h0, 1, 0, 0, 0, 0, 8, 0);
    add(1, 1, 1, 0, SOFI3, 1, 0, 0, 1, 1, 8, 0);
    for (int k = 1; k <= 9; k++) add(1, 1, 0, 0, 32'hF00F_0000 + k, 1, 0, 0, 1, 1, 7, 0);
    add(1, 1, 0, 1, EOFT, 1, 0, 0, 1, 1, 7, 0);
    add(1, 0, 0, 0, 32'h0, 1, 0, 0, 0, 0, 7, 0);
    for (int k = 1; k <= 3; k++) add(1, 1, 0, 0, 32'hDEAD_0000 + k, 1, 0, 0, 0, 1, 7, 0);
    add(1, 0, 0, 0, 32'h0, 1, 0, 1, 0, 0, 7, 0);
    add(1, 0, 0, 0, 32'h0, 1, 0, 0, 0, 0, 7, 1);
    add(1, 0, 0, 0, 32'h0, 1, 0, 0, 1, 0, 7, 1);
    add(1, 0, 0, 0, 32'h0, 1, 0, 0, 0, 0, 7, 0);

    model_reset();
    #1;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
    chk("reset_credit", {28'd0, credit_avail}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1;

    foreach (tbl[i]) begin
      link = tbl[i].lk; in_valid = tbl[i].v; in_sop = tbl[i].s; in_eop = tbl[i].e;
      in_data = tbl[i].d; out_ready = tbl[i].rdy; rx_rrdy = tbl[i].rr; rx_done = tbl[i].rd;
      step_eval();
      chk($sformatf("tbl%0d_out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].eov});
      chk($sformatf("tbl%0d_in_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].eir});
      chk($sformatf("tbl%0d_credit", i), {28'd0, credit_avail}, tbl[i].ecred);
      chk($sformatf("tbl%0d_pending", i), {28'd0, rrdy_pending}, tbl[i].epend);
      if (tbl[i].eov) chk($sformatf("tbl%0d_data", i), out_data, (tbl[i].epend != 0) ? RRDY : tbl[i].d);
      step_adv();
    end
    in_valid = 0;
    chk("drop_after_3", {16'd0, drop_count}, 32'd3);

    // Credit exhaustion: restore to 8, send 9 single-word frames.
    rx_rrdy = 1; step();
    chk("credit_restored", {28'd0, credit_avail}, 32'd8);
    for (int k = 0; k < 8; k++) xfer(32'h1000_0000 + k, 1, 1);
    in_valid = 1; in_sop = 1; in_eop = 1; in_data = 32'h1000_0008;
    for (int k = 0; k < 3; k++) begin
      step_eval();
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_credit", {28'd0, credit_avail}, 32'd0);
      step_adv();
    end
    rx_rrdy = 1;
    xfer(32'h1000_0008, 1, 1);
    step();
    chk("ninth_frame_credit", {28'd0, credit_avail}, 32'd0);

    // rx_rrdy coinciding with a SOF handshake leaves credit unchanged.
    rx_rrdy = 1; step();
    rx_rrdy = 1; step();
    chk("credit_two", {28'd0, credit_avail}, 32'd2);
    rx_rrdy = 1;
    xfer(32'h2000_0000, 1, 1);
    step();
    chk("sof_rrdy_same_cycle", {28'd0, credit_avail}, 32'd2);

    // R_RDYs owed during a frame with a stuttering sink come out after EOF.
    rdy_toggle = 1;
    xfer(SOFI3, 1, 0);
    xfer(32'h3000_0001, 0, 0);
    rx_done = 1;
    xfer(32'h3000_0002, 0, 0);
    xfer(32'h3000_0003, 0, 0);
    rx_done = 1;
    xfer(32'h3000_0004, 0, 0);
    xfer(EOFT, 0, 1);
    rdy_toggle = 0; out_ready = 1;
    rrdy_seen = 0;
    for (int k = 0; k < 6; k++) begin
      step_eval();
      if (out_valid && out_data == RRDY && out_sop && out_eop) rrdy_seen++;
      step_adv();
    end
    chk("rrdy_words_emitted", rrdy_seen, 32'd2);
    chk("rrdy_pending_drained", {28'd0, rrdy_pending}, 32'd0);

    // Over-return of credit sets the sticky error.
    while (m_credit < BB) begin rx_rrdy = 1; step(); end
    rx_rrdy = 1; step();
    chk("credit_error_set", {31'd0, credit_error}, 32'd1);
    for (int k = 0; k < 3; k++) step();
    chk("credit_error_sticky", {31'd0, credit_error}, 32'd1);

    // Link drop mid-frame: frame still completes, counters clear, new SOF stalls.
    xfer(SOFI3, 1, 0);
    xfer(32'h4000_0001, 0, 0);
    link = 0;
    xfer(32'h4000_0002, 0, 0);
    xfer(EOFT, 0, 1);
    step();
    chk("linkdown_credit", {28'd0, credit_avail}, 32'd0);
    chk("linkdown_pending", {28'd0, rrdy_pending}, 32'd0);
    in_valid = 1; in_sop = 1; in_eop = 1; in_data = 32'h4000_0003;
    for (int k = 0; k < 3; k++) begin
      step_eval();
      chk("linkdown_sof_stall", {31'd0, in_ready}, 32'd0);
      step_adv();
    end
    in_valid = 0; link = 1;
    step(); step();
    chk("linkup_credit", {28'd0, credit_avail}, 32'd8);
    chk("linkup_error_clear", {31'd0, credit_error}, 32'd0);

    // Reset asserted mid-frame, then while an R_RDY is waiting on the sink.
    xfer(SOFI3, 1, 0);
    in_valid = 1; in_data = 32'h5000_0001;
    reset_check("rst_frame");
    step(); step();
    chk("rst_frame_relink_credit", {28'd0, credit_avail}, 32'd8);
    rx_done = 1; step();
    step();
    out_ready = 0;
    step_eval();
    chk("rrdy_held_valid", {31'd0, out_valid}, 32'd1);
    step_adv();
    reset_check("rst_rrdy");
    step(); step();
    chk("rst_rrdy_relink_credit", {28'd0, credit_avail}, 32'd8);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) == 0) link = ~link;
      in_valid  = ($urandom_range(0, 9) < 7);
      in_sop    = ($urandom_range(0, 3) == 0);
      in_eop    = ($urandom_range(0, 9) < 3);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      rx_rrdy   = ($urandom_range(0, 6) == 0);
      rx_done   = ($urandom_range(0, 6) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
